// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage sitting directly in front of the control unit. It owns the PC,
// fetches one 32-bit instruction word per instruction from instruction memory
// over a req/ack handshake, latches it into IR and presents IR[31:26] as the
// control unit's opcode. The control unit answers during the one-cycle EXEC
// window with PCWre/PCSrc, and together with the sign-extended immediate this
// forms the next PC. PCWre=0 parks the unit in HALT. A missing ack parks it
// in FAULT. Only reset leaves HALT or FAULT.
//
// Ports
//   clk_i         sole clock, rising edge
//   rst_i         asynchronous, active-high reset
//   pc_wre_i      1 = advance PC after EXEC, 0 = halt
//   pc_src_i      1 = take branch (PC+4 + ExtImm*4)
//   ext_imm_i     sign-extended immediate, signed word offset
//   imem_req_o    fetch request, high for every FETCH cycle
//   imem_addr_o   fetch address (the PC)
//   imem_ack_i    memory returns data this cycle
//   imem_rdata_i  instruction word, valid with imem_ack_i
//   ir_o          latched instruction
//   decode_o      ir_o[31:26], opcode for the control unit
//   ins_valid_o   high only in EXEC
//   cur_pc_o      address of the instruction held in ir_o
//   halted_o      high in HALT
//   fault_o       high in FAULT (fetch ack timeout or corrupted state)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int unsigned       TIMEOUT  = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pc_wre_i,
  input  logic              pc_src_i,
  input  logic [31:0]       ext_imm_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       ir_o,
  output logic [5:0]        decode_o,
  output logic              ins_valid_o,
  output logic [ADDR_W-1:0] cur_pc_o,
  output logic              halted_o,
  output logic              fault_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_HALT  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  // Last wait-count value before the timeout fires; the ack is still honoured
  // in that cycle, so the fault lands after exactly TIMEOUT unacked cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [2:0]        state_q,  state_d;
  logic [ADDR_W-1:0] pc_q,     pc_d;
  logic [ADDR_W-1:0] cur_pc_q, cur_pc_d;
  logic [31:0]       ir_q,     ir_d;
  logic [7:0]        cnt_q,    cnt_d;
  logic              imem_req_q;
  logic              ins_valid_q;
  logic              halted_q;
  logic              fault_q;

  // Branch offset: sign-extend the immediate to at least ADDR_W bits, then
  // shift by two (word -> byte) and truncate to ADDR_W.
  logic [ADDR_W+31:0] ext_wide_s;
  logic [ADDR_W-1:0]  br_off_s;
  logic [ADDR_W-1:0]  pc_seq_s;
  logic [ADDR_W-1:0]  pc_next_s;
  logic               unused_ext_s;

  assign ext_wide_s   = {{ADDR_W{ext_imm_i[31]}}, ext_imm_i};
  assign br_off_s     = {ext_wide_s[ADDR_W-3:0], 2'b00};
  // High bits of the widened immediate fall off the truncated offset.
  assign unused_ext_s = ^ext_wide_s[ADDR_W+31:ADDR_W-2];

  // Sequential PC and taken-branch PC; both adds wrap modulo 2^ADDR_W.
  always_comb begin
    pc_seq_s = pc_q + ADDR_W'(4);
    if (pc_src_i) begin
      pc_next_s = pc_seq_s + br_off_s;
    end else begin
      pc_next_s = pc_seq_s;
    end
  end

  // Next-state logic for the fetch FSM and its datapath registers.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cur_pc_d = cur_pc_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack_i) begin
          ir_d     = imem_rdata_i;
          cur_pc_d = pc_q;
          cnt_d    = 8'd0;
          state_d  = ST_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_FAULT;
        end else begin
          cnt_d    = cnt_q + 8'd1;
        end
      end
      ST_EXEC: begin
        if (pc_wre_i) begin
          pc_d    = pc_next_s;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        // Unreachable encoding: park in FAULT rather than guess a state.
        state_d = ST_FAULT;
      end
    endcase
  end

  // State and datapath registers; reset abandons any request in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      cur_pc_q <= RESET_PC;
      ir_q     <= 32'd0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cur_pc_q <= cur_pc_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
    end
  end

  // Status outputs registered from the next state so they are glitch-free
  // and line up exactly with the state they describe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      imem_req_q  <= 1'b0;
      ins_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      imem_req_q  <= (state_d == ST_FETCH);
      ins_valid_q <= (state_d == ST_EXEC);
      halted_q    <= (state_d == ST_HALT);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign imem_req_o  = imem_req_q;
  assign imem_addr_o = pc_q;
  assign ir_o        = ir_q;
  assign decode_o    = ir_q[31:26];
  assign ins_valid_o = ins_valid_q;
  assign cur_pc_o    = cur_pc_q;
  assign halted_o    = halted_q;
  assign fault_o     = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a table of instructions walks the
// unit through sequential fetch, branches, address wrap, a late ack and a
// halt; hand-written sequences cover reset mid-fetch and the ack timeout.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_wre;
  logic        pc_src;
  logic [31:0] ext_imm;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [5:0]  decode;
  logic        ins_valid;
  logic [31:0] cur_pc;
  logic        halted;
  logic        fault;

  instr_fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (15)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pc_wre_i     (pc_wre),
    .pc_src_i     (pc_src),
    .ext_imm_i    (ext_imm),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ack_i   (imem_ack),
    .imem_rdata_i (imem_rdata),
    .ir_o         (ir),
    .decode_o     (decode),
    .ins_valid_o  (ins_valid),
    .cur_pc_o     (cur_pc),
    .halted_o     (halted),
    .fault_o      (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;   // expected fetch address
    logic [31:0] rdata;  // word returned by memory
    int          delay;  // unacked FETCH cycles before the ack
    logic        wre;
    logic        src;
    logic [31:0] imm;
    logic [5:0]  dec;    // expected opcode
  } vec_t;

  typedef struct {
    logic [31:0] ir;
    logic [5:0]  dec;
    logic [31:0] pc;
  } exp_t;

  vec_t vecs [8];
  exp_t sb_q [$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Wait (sampling on negedges) until a fetch request is visible.
  task automatic wait_req(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (imem_req === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    check("wait_req", 32'(seen), 32'd1);
  endtask

  initial begin
    exp_t e;
    int   bad;
    int   stall_bad;

    //            addr           rdata          dly wre   src   imm            dec
    vecs[0] = '{32'h0000_0000, 32'h0400_0001, 0,  1'b1, 1'b0, 32'h0000_0000, 6'h01};
    vecs[1] = '{32'h0000_0004, 32'h0800_0002, 0,  1'b1, 1'b0, 32'h0000_0000, 6'h02};
    vecs[2] = '{32'h0000_0008, 32'h1000_0003, 2,  1'b1, 1'b1, 32'hFFFF_FFFE, 6'h04};
    vecs[3] = '{32'h0000_0004, 32'h1400_0004, 0,  1'b1, 1'b0, 32'h0000_0000, 6'h05};
    vecs[4] = '{32'h0000_0008, 32'h1800_0005, 1,  1'b1, 1'b1, 32'h0000_0003, 6'h06};
    vecs[5] = '{32'h0000_0018, 32'h2000_0006, 0,  1'b1, 1'b1, 32'hFFFF_FFF8, 6'h08};
    vecs[6] = '{32'hFFFF_FFFC, 32'h2400_0007, 14, 1'b1, 1'b0, 32'h0000_0000, 6'h09};
    vecs[7] = '{32'h0000_0000, 32'hFC00_0000, 0,  1'b0, 1'b0, 32'h0000_0000, 6'h3F};

    rst = 1'b1; pc_wre = 1'b0; pc_src = 1'b0; ext_imm = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_req",    32'(imem_req),  32'd0);
    check("rst_valid",  32'(ins_valid), 32'd0);
    check("rst_halted", 32'(halted),    32'd0);
    check("rst_fault",  32'(fault),     32'd0);
    check("rst_ir",     ir,             32'd0);
    check("rst_decode", 32'(decode),    32'd0);
    check("rst_addr",   imem_addr,      32'd0);
    check("rst_curpc",  cur_pc,         32'd0);

    rst = 1'b0;
    @(negedge clk);
    check("idle_to_fetch", 32'(imem_req), 32'd1);

    // Table-driven instruction stream
    for (int v = 0; v < 8; v++) begin
      wait_req(4);
      check($sformatf("v%0d_addr", v), imem_addr, vecs[v].addr);
      sb_q.push_back('{vecs[v].rdata, vecs[v].dec, vecs[v].addr});
      // Control inputs carry junk during FETCH; only EXEC may sample them.
      pc_wre = ~vecs[v].wre; pc_src = 1'b1; ext_imm = 32'h0000_0100;
      stall_bad = 0;
      for (int k = 0; k < vecs[v].delay; k++) begin
        imem_ack = 1'b0;
        @(negedge clk);
        if (imem_req !== 1'b1 || fault !== 1'b0) stall_bad++;
      end
      check($sformatf("v%0d_stall", v), 32'(stall_bad), 32'd0);
      imem_ack = 1'b1; imem_rdata = vecs[v].rdata;
      @(negedge clk);
      // EXEC: a stray ack here must be ignored.
      imem_rdata = 32'hDEAD_BEEF;
      check($sformatf("v%0d_valid", v), 32'(ins_valid), 32'd1);
      check($sformatf("v%0d_req_exec", v), 32'(imem_req), 32'd0);
      if (sb_q.size() == 0) begin
        check($sformatf("v%0d_sb_empty", v), 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("v%0d_ir", v),     ir,          e.ir);
        check($sformatf("v%0d_decode", v), 32'(decode), 32'(e.dec));
        check($sformatf("v%0d_curpc", v),  cur_pc,      e.pc);
      end
      pc_wre = vecs[v].wre; pc_src = vecs[v].src; ext_imm = vecs[v].imm;
      @(negedge clk);
      imem_ack = 1'b0;
      check($sformatf("v%0d_valid_off", v), 32'(ins_valid), 32'd0);
      if (vecs[v].wre) check($sformatf("v%0d_refetch", v), 32'(imem_req), 32'd1);
      else             check($sformatf("v%0d_halted", v),  32'(halted),   32'd1);
    end

    // Halt holds for 20 cycles, ignoring ack and PCWre.
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111; pc_wre = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || ir !== 32'hFC00_0000 || halted !== 1'b1 || ins_valid !== 1'b0) bad++;
    end
    check("halt_hold",   32'(bad),    32'd0);
    check("halt_decode", 32'(decode), 32'h3F);
    check("halt_pc",     imem_addr,   32'd0);
    check("halt_fault",  32'(fault),  32'd0);

    // Reset in the middle of a FETCH.
    imem_ack = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_req(4);
    imem_ack = 1'b1; imem_rdata = 32'h0C00_0000;
    @(negedge clk);
    imem_ack = 1'b0; pc_wre = 1'b1; pc_src = 1'b0;
    @(negedge clk);
    check("mid_fetch_addr", imem_addr, 32'd4);
    #2 rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
    #1;
    check("mf_rst_req",    32'(imem_req),  32'd0);
    check("mf_rst_addr",   imem_addr,      32'd0);
    check("mf_rst_ir",     ir,             32'd0);
    check("mf_rst_decode", 32'(decode),    32'd0);
    check("mf_rst_curpc",  cur_pc,         32'd0);
    check("mf_rst_flags",  32'({ins_valid, halted, fault}), 32'd0);
    repeat (2) @(negedge clk);
    imem_ack = 1'b0;
    rst = 1'b0;

    // Ack timeout: 15 unacked FETCH cycles then FAULT; later ack ignored.
    @(negedge clk);
    check("to_fetch_start", 32'(imem_req), 32'd1);
    bad = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (imem_req !== 1'b1 || fault !== 1'b0) bad++;
    end
    check("to_no_early_fault", 32'(bad), 32'd0);
    @(negedge clk);
    check("to_fault", 32'(fault),    32'd1);
    check("to_req",   32'(imem_req), 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    check("to_late_ack_ir", ir,           32'd0);
    check("to_fault_hold",  32'(fault),   32'd1);
    check("to_flags",       32'({ins_valid, halted, imem_req}), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
